// File: rtl/spi_sequencer.sv
// Round-robin sequencer driving one SPI master register port for two requesters.
// Optional STATUS poll timeout is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_sequencer #(
    parameter logic [15:0] POLL_MAX = 16'd1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_ctrl,
    input  logic [15:0] i_tx,
    output logic [1:0]  o_done,
    output logic [7:0]  o_rx,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_en,
    output logic        o_wr,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_wdata,
    input  logic [7:0]  i_rdata
);

    typedef enum logic [3:0] {
        IDLE, WR_CTRL, WR_DATA, POLL_RD, POLL_CHK, RD_DATA, RD_WAIT, RELEASE, DONE
    } state_t;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_DOUT   = 4'd1;
    localparam logic [3:0] ADDR_DIN    = 4'd2;
    localparam logic [3:0] ADDR_CTRL   = 4'd3;
    localparam logic [7:0] SS_BIT      = 8'h04;

    state_t     state, state_nxt;
    logic       gnt_nxt, gnt_idx, last_gnt;
    logic [7:0] ctrl_q, tx_q, rx_q;
    logic [1:0] done_q;
    logic       poll_expired;
    logic       grant;

    assign grant = (state == IDLE) && (|i_req);

    // Requester 1 only wins a tie when requester 0 was served last.
    always_comb begin
        gnt_nxt = 1'b0;
        case (i_req)
            2'b10:   gnt_nxt = 1'b1;
            2'b11:   gnt_nxt = ~last_gnt;
            default: gnt_nxt = 1'b0;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|i_req) state_nxt = WR_CTRL;
            WR_CTRL:  state_nxt = WR_DATA;
            WR_DATA:  state_nxt = POLL_RD;
            POLL_RD:  state_nxt = POLL_CHK;
            POLL_CHK: begin
                if (!i_rdata[0])       state_nxt = RD_DATA;
                else if (poll_expired) state_nxt = RELEASE;
                else                   state_nxt = POLL_RD;
            end
            RD_DATA:  state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RELEASE;
            RELEASE:  state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        o_en    = 1'b0;
        o_wr    = 1'b0;
        o_addr  = ADDR_STATUS;
        o_wdata = 8'h00;
        case (state)
            WR_CTRL: begin
                o_en = 1'b1; o_wr = 1'b1; o_addr = ADDR_CTRL; o_wdata = ctrl_q | SS_BIT;
            end
            WR_DATA: begin
                o_en = 1'b1; o_wr = 1'b1; o_addr = ADDR_DOUT; o_wdata = tx_q;
            end
            POLL_RD: begin
                o_en = 1'b1; o_addr = ADDR_STATUS;
            end
            RD_DATA: begin
                o_en = 1'b1; o_addr = ADDR_DIN;
            end
            RELEASE: begin
                o_en = 1'b1; o_wr = 1'b1; o_addr = ADDR_CTRL; o_wdata = ctrl_q & ~SS_BIT;
            end
            default: ;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_gnt <= 1'b1;
            gnt_idx  <= 1'b0;
            ctrl_q   <= 8'h00;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            done_q   <= 2'b00;
        end else begin
            done_q <= 2'b00;
            if (grant) begin
                gnt_idx <= gnt_nxt;
                ctrl_q  <= gnt_nxt ? i_ctrl[15:8] : i_ctrl[7:0];
                tx_q    <= gnt_nxt ? i_tx[15:8]   : i_tx[7:0];
            end
            if (state == RD_WAIT) rx_q <= i_rdata;
            // A timed-out transfer reports an all-zero byte.
            if (state == POLL_CHK && i_rdata[0] && poll_expired) rx_q <= 8'h00;
            if (state == DONE) begin
                done_q   <= gnt_idx ? 2'b10 : 2'b01;
                last_gnt <= gnt_idx;
            end
        end
    end

    assign o_done = done_q;
    assign o_rx   = rx_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        timeout_q;
    logic        err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            poll_cnt  <= 16'd0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (grant) begin
                poll_cnt  <= 16'd0;
                timeout_q <= 1'b0;
            end else if (state == POLL_RD) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            if (state == POLL_CHK && i_rdata[0] && poll_expired) timeout_q <= 1'b1;
            if (state == DONE) err_q <= timeout_q;
        end
    end

    assign poll_expired = (poll_cnt >= POLL_MAX);
    assign o_err        = err_q;
`else
    assign poll_expired = 1'b0;
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed bench for spi_sequencer: a register-port slave model plus bus and
// completion scoreboards fed by the stimulus and drained by a negedge monitor.
module tb_spi_sequencer;

    typedef struct {
        logic [1:0] done;
        logic [7:0] rx;
        logic       err;
        int         lat;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] ctrl = 16'h0000;
    logic [15:0] tx = 16'h0000;
    logic [7:0]  rdata = 8'h00;
    logic [1:0]  o_done;
    logic [7:0]  o_rx;
    logic        o_err, o_busy, o_en, o_wr;
    logic [3:0]  o_addr;
    logic [7:0]  o_wdata;

    logic [12:0] exp_bus[$];
    done_t       exp_done[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int grant_cyc = 0;
    int done_seen = 0;
    int busy_polls = 0;
    int poll_idx = 0;
    logic [7:0] data_in = 8'h00;
    logic       rd_seen = 1'b0;
    logic       wr1_seen = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    logic       mon_en = 1'b0;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_done = 2'b00;

    spi_sequencer #(.POLL_MAX(16'd4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_ctrl (ctrl),
        .i_tx   (tx),
        .o_done (o_done),
        .o_rx   (o_rx),
        .o_err  (o_err),
        .o_busy (o_busy),
        .o_en   (o_en),
        .o_wr   (o_wr),
        .o_addr (o_addr),
        .o_wdata(o_wdata),
        .i_rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Slave model: registered read data one cycle after the access; STATUS
    // reports busy for the first busy_polls polls after each DATA_OUT write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr1_seen) begin
            poll_idx <= 0;
        end else if (rd_seen) begin
            if (rd_addr == 4'd0) begin
                rdata    <= (poll_idx < busy_polls) ? 8'h01 : 8'h00;
                poll_idx <= poll_idx + 1;
            end else begin
                rdata <= data_in;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [12:0] e, obs;
        done_t d;
        rd_seen  = 1'b0;
        wr1_seen = 1'b0;
        if (mon_en) begin
            if (o_en) begin
                check("bus_pending", exp_bus.size() > 0, 1);
                if (exp_bus.size() > 0) begin
                    e   = exp_bus.pop_front();
                    obs = o_wr ? {1'b1, o_addr, o_wdata} : {1'b0, o_addr, 8'h00};
                    check("bus_op", obs, e);
                end
                rd_seen  = !o_wr;
                rd_addr  = o_addr;
                wr1_seen = o_wr && (o_addr == 4'd1);
            end
            if (o_busy && !prev_busy) grant_cyc = cyc - 1;
            if (prev_done != 2'b00) check("done_width", o_done, 0);
            if (o_done != 2'b00) begin
                done_seen++;
                check("done_pending", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    check("done_vec", o_done, d.done);
                    check("done_rx", o_rx, d.rx);
                    check("done_err", o_err, d.err);
                    check("latency", cyc - grant_cyc, d.lat);
                end
            end
            prev_busy = o_busy;
            prev_done = o_done;
        end
    end

    task automatic push_bus(input logic wr, input logic [3:0] addr, input logic [7:0] data);
        exp_bus.push_back({wr, addr, data});
    endtask

    task automatic push_xfer(input logic idx, input logic [7:0] c, input logic [7:0] t,
                             input int polls, input logic [7:0] rx);
        done_t d;
        push_bus(1'b1, 4'd3, c | 8'h04);
        push_bus(1'b1, 4'd1, t);
        for (int i = 0; i <= polls; i++) push_bus(1'b0, 4'd0, 8'h00);
        push_bus(1'b0, 4'd2, 8'h00);
        push_bus(1'b1, 4'd3, c & 8'hFB);
        d.done = idx ? 2'b10 : 2'b01;
        d.rx   = rx;
        d.err  = 1'b0;
        d.lat  = 9 + 2 * polls;
        exp_done.push_back(d);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while ((o_busy || exp_bus.size() != 0 || exp_done.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < budget, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},  o_done,  0);
        check({tag, "_rx"},    o_rx,    0);
        check({tag, "_err"},   o_err,   0);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_en"},    o_en,    0);
        check({tag, "_wr"},    o_wr,    0);
        check({tag, "_addr"},  o_addr,  0);
        check({tag, "_wdata"}, o_wdata, 0);
    endtask

    initial begin
        int n, k, done_before;

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single transfer from requester 0, STATUS idle on the first poll.
        ctrl = {8'hF1, 8'h0A};
        tx   = {8'h77, 8'h5A};
        data_in = 8'hC3;
        busy_polls = 0;
        push_xfer(1'b0, 8'h0A, 8'h5A, 0, 8'hC3);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_idle("single_idle", 60);
        repeat (3) @(negedge clk);
        check("rx_hold", o_rx, 8'hC3);

        // Busy stretch on requester 1 with slave select already set in ctrl.
        ctrl = {8'hE4, 8'h0A};
        tx   = {8'hA5, 8'h5A};
        data_in = 8'h3C;
        busy_polls = 3;
        push_xfer(1'b1, 8'hE4, 8'hA5, 3, 8'h3C);
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        wait_idle("stretch_idle", 60);

        // Tie held across three back-to-back transfers: 0, 1, 0.
        data_in = 8'h99;
        busy_polls = 0;
        push_xfer(1'b0, 8'h0A, 8'h5A, 0, 8'h99);
        push_xfer(1'b1, 8'hE4, 8'hA5, 0, 8'h99);
        push_xfer(1'b0, 8'h0A, 8'h5A, 0, 8'h99);
        req = 2'b11;
        n = 0;
        k = 0;
        while (n < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (o_done != 2'b00) n++;
        end
        check("tie_progress", n, 2);
        @(negedge clk);
        req = 2'b00;
        wait_idle("tie_idle", 60);

        // Requester 1 arrives mid-transfer while requester 0's inputs change.
        ctrl = {8'h13, 8'h21};
        tx   = {8'h6C, 8'h42};
        data_in = 8'h5E;
        push_xfer(1'b0, 8'h21, 8'h42, 0, 8'h5E);
        push_xfer(1'b1, 8'h13, 8'h6C, 0, 8'h5E);
        req = 2'b01;
        @(negedge clk);
        req = 2'b10;
        ctrl[7:0] = 8'hFF;
        tx[7:0]   = 8'h00;
        k = 0;
        while (o_done !== 2'b01 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("change_done0", o_done, 2'b01);
        @(negedge clk);
        check("change_grant1", o_busy, 1);
        req = 2'b00;
        wait_idle("change_idle", 60);

        // Reset in POLL_CHK: no release write, no completion.
        ctrl = {8'h13, 8'h0A};
        tx   = {8'h6C, 8'h5A};
        busy_polls = 100;
        push_bus(1'b1, 4'd3, 8'h0E);
        push_bus(1'b1, 4'd1, 8'h5A);
        push_bus(1'b0, 4'd0, 8'h00);
        done_before = done_seen;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_bus_left", exp_bus.size(), 0);
        check("midrst_no_done", done_seen, done_before);

`ifdef SPI_SEQ_TIMEOUT_EN
        // STATUS stuck busy: four polls, release, error completion, then recovery.
        begin
            done_t d;
            push_bus(1'b1, 4'd3, 8'h0E);
            push_bus(1'b1, 4'd1, 8'h5A);
            for (int i = 0; i < 4; i++) push_bus(1'b0, 4'd0, 8'h00);
            push_bus(1'b1, 4'd3, 8'h0A);
            d.done = 2'b01;
            d.rx   = 8'h00;
            d.err  = 1'b1;
            d.lat  = 13;
            exp_done.push_back(d);
        end
        data_in = 8'hC3;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_idle("timeout_idle", 80);
        busy_polls = 0;
        push_xfer(1'b0, 8'h0A, 8'h5A, 0, 8'hC3);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_idle("recover_idle", 60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sequencer.md
SPI_SEQUENCER -- requirements
Module: spi_sequencer

Interface
REQ-001 SHALL have parameter POLL_MAX, default 16'd1000, the maximum STATUS polls per transfer (used only when SPI_SEQ_TIMEOUT_EN is defined).
REQ-002 SHALL have the following ports, in order:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_req  input  2  transfer request, one bit per requester (bit0 = requester 0).
- i_ctrl  input  16  SPI CTRL byte per requester ([7:0] = requester 0, [15:8] = requester 1).
- i_tx  input  16  transmit byte per requester (same packing).
- o_done  output  2  one-cycle completion pulse per requester.
- o_rx  output  8  received byte, valid while o_done is nonzero.
- o_err  output  1  timeout flag, pulses with o_done.
- o_busy  output  1  high whenever the FSM is not in IDLE.
- o_en  output  1  SPI master register-port enable.
- o_wr  output  1  SPI master write strobe (0 = read, 1 = write).
- o_addr  output  4  SPI master register address (0 = STATUS, 1 = DATA_OUT, 2 = DATA_IN, 3 = CTRL).
- o_wdata  output  8  SPI master write data.
- i_rdata  input  8  SPI master read data, registered; valid the cycle after the read access.

Function
REQ-003 SHALL make every register access a single cycle with o_en=1; o_en SHALL be 0 in all other states.
REQ-004 SHALL implement the FSM states IDLE, WR_CTRL, WR_DATA, POLL_RD, POLL_CHK, RD_DATA, RD_WAIT, RELEASE, DONE.
REQ-005 SHALL, in IDLE with any i_req bit set, grant round-robin:
- A single requester is granted directly.
- When both request, the requester not granted last wins.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-006 SHALL, on grant, latch that requester's i_ctrl and i_tx slices, then go to WR_CTRL.
REQ-007 SHALL, in WR_CTRL, write addr 3 with the latched ctrl and bit 2 forced to 1 (slave select asserted), then go to WR_DATA.
REQ-008 SHALL, in WR_DATA, write addr 1 with the latched tx byte, then go to POLL_RD.
REQ-009 SHALL, in POLL_RD, read addr 0; in the following cycle (POLL_CHK, o_en=0) it SHALL test i_rdata[0]: if 1, return to POLL_RD; if 0, go to RD_DATA.
REQ-010 SHALL, in RD_DATA, read addr 2; in RD_WAIT it SHALL capture i_rdata into the rx register.
REQ-011 SHALL, in RELEASE, write addr 3 with the latched ctrl and bit 2 forced to 0 (slave select deasserted).
REQ-012 SHALL, in DONE, pulse o_done[granted] for exactly one cycle with o_rx valid, update the last-grant pointer, then return to IDLE.
REQ-013 SHALL hold o_rx until the next RD_WAIT capture.
REQ-014 SHALL re-arbitrate from IDLE the cycle after DONE; an i_req bit still high at that point SHALL be treated as a new transfer.
REQ-015 SHALL ignore i_req, i_ctrl and i_tx changes outside IDLE.
REQ-016 SHALL give a minimum transfer latency of 9 cycles from the grant cycle to the o_done pulse when the first poll reads not-busy.

Reset
REQ-017 SHALL, when i_rst_n=0 at a rising edge, force the state to IDLE and clear:
- o_done = 0, o_rx = 8'h00, o_err = 0, o_busy = 0
- o_en = 0, o_wr = 0, o_addr = 4'h0, o_wdata = 8'h00
- last-grant pointer = 1, poll counter = 0
REQ-018 SHALL, on reset during a transfer, abandon it with no RELEASE write and no o_done pulse.

Configuration
REQ-019 SHALL, with SPI_SEQ_TIMEOUT_EN defined, apply the poll timeout:
- Count POLL_RD entries per transfer; the count is cleared at grant.
- When the count reaches POLL_MAX while busy is still set, go from POLL_CHK to RELEASE, skipping RD_DATA and RD_WAIT.
- Set o_rx = 8'h00 and pulse o_err together with o_done.
REQ-020 SHALL, without SPI_SEQ_TIMEOUT_EN, poll indefinitely, omit the poll counter, and tie o_err to 0.

Verification
REQ-021 Single transfer: req0 with ctrl=8'h0A, tx=8'h5A; STATUS idle on the first poll; DATA_IN=8'hC3 -> bus sequence is W3:0E, W1:5A, R0, R2, W3:0A; o_done=2'b01 with o_rx=C3 exactly 9 cycles after grant.
REQ-022 Tie: i_req=2'b11 held through three transfers -> grants go 0, 1, 0; each o_done pulse is a single cycle.
REQ-023 Busy stretch: STATUS reads 01, 01, 01, then 00 -> 4 POLL_RD accesses; latency is 15 cycles.
REQ-024 Timeout (macro defined, POLL_MAX=4, STATUS stuck at 01): 4 polls, then W3 with bit 2 = 0; o_done and o_err pulse with o_rx=00.
REQ-025 Reset mid-poll: i_rst_n=0 for 1 cycle -> all outputs at their reset values the next cycle; no RELEASE write; no o_done.
REQ-026 Request change during a transfer: req1 asserts mid-transfer of req0 -> the latched data is unaffected; req1 is granted in the IDLE cycle after DONE.
